// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared op format, field widths and blitter states for the rectangle blitter
package gpu_pkg;

   localparam int X_W        = 10;
   localparam int Y_W        = 9;
   localparam int SCALE_W    = 3;
   localparam int COLOR_W    = 12;
   localparam int MEM_ADDR_W = 12;

   typedef struct packed {
      logic [X_W-1:0]        x;
      logic [Y_W-1:0]        y;
      logic [X_W-1:0]        width;
      logic [Y_W-1:0]        height;
      logic [COLOR_W-1:0]    color;
      logic                  mem_en;
      logic [MEM_ADDR_W-1:0] mem_addr;
      logic [SCALE_W-1:0]    scale;
   } gpu_op_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_DRAW,
      ST_DRAIN
   } blit_state_t;

endpackage

// File: rtl/gpu_tex_stepper.sv
// rtl/gpu_tex_stepper.sv - col/row walker with scale-aware texel address and end-of-rect flag
module gpu_tex_stepper
   import gpu_pkg::*;
#(
   parameter int ROM_ADDR_W = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  step,
   input  logic [X_W-1:0]        width,
   input  logic [Y_W-1:0]        height,
   input  logic [SCALE_W-1:0]    scale,
   input  logic [ROM_ADDR_W-1:0] base,
   output logic                  col_end,
   output logic                  last,
   output logic [ROM_ADDR_W-1:0] tex_addr
);

   logic [X_W-1:0]        col;
   logic [Y_W-1:0]        row;
   logic [Y_W:0]          row_next;
   logic [Y_W:0]          row_mask;
   logic [ROM_ADDR_W-1:0] tex_row_base;
   logic [ROM_ADDR_W-1:0] stride;

   assign stride   = ROM_ADDR_W'(width >> scale);
   assign row_mask = ~({(Y_W+1){1'b1}} << scale);
   assign row_next = {1'b0, row} + (Y_W+1)'(1);
   assign col_end  = (col == width - 1'b1);
   assign last     = col_end && (row == height - 1'b1);
   assign tex_addr = tex_row_base + ROM_ADDR_W'(col >> scale);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col          <= '0;
         row          <= '0;
         tex_row_base <= '0;
      end else if (start) begin
         col          <= '0;
         row          <= '0;
         tex_row_base <= base;
      end else if (step) begin
         if (col_end) begin
            col <= '0;
            row <= row + 1'b1;
            // each texel row is repeated 2^scale times before moving on
            if ((row_next & row_mask) == '0)
               tex_row_base <= tex_row_base + stride;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/gpu_rect_blitter.sv
// rtl/gpu_rect_blitter.sv - rasterises one fill/sprite rectangle per op into the framebuffer
// Optional colour-key transparency for sprites: GPU_TRANSPARENCY_EN.
module gpu_rect_blitter
   import gpu_pkg::*;
#(
   parameter int                 HOR_ACTIVE_PIXELS = 640,
   parameter int                 VER_ACTIVE_PIXELS = 480,
   parameter int                 ROM_ADDR_W        = 12,
   parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = 12'hF0F,
   localparam int                FB_AW = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  gpu_op_t               op,
   input  logic                  op_valid,
   output logic                  op_ready,
   output logic [ROM_ADDR_W-1:0] rom_addr,
   input  logic [COLOR_W-1:0]    rom_data,
   output logic                  fb_wr_en,
   output logic [FB_AW-1:0]      fb_wr_addr,
   output logic [COLOR_W-1:0]    fb_wr_data
);

`ifdef GPU_TRANSPARENCY_EN
   localparam bit KEY_EN = 1'b1;
`else
   localparam bit KEY_EN = 1'b0;
`endif

   localparam logic [FB_AW-1:0] PITCH = FB_AW'(HOR_ACTIVE_PIXELS);
   localparam logic [X_W:0]     X_LIM = (X_W+1)'(HOR_ACTIVE_PIXELS);
   localparam logic [Y_W:0]     Y_LIM = (Y_W+1)'(VER_ACTIVE_PIXELS);

   blit_state_t      state;
   blit_state_t      next_state;
   gpu_op_t          op_q;
   logic             accept;
   logic             setup;
   logic             step;
   logic             zero_size;
   logic             col_end;
   logic             last;
   logic             in_bounds;
   logic [FB_AW-1:0] base_addr;
   logic [FB_AW-1:0] row_addr;
   logic [FB_AW-1:0] pix_addr;
   logic [X_W:0]     px;
   logic [Y_W:0]     py;
   logic             s1_valid;
   logic [FB_AW-1:0] s1_addr;

   assign zero_size = (op_q.width == '0) || (op_q.height == '0);
   assign base_addr = FB_AW'(op_q.y) * PITCH + FB_AW'(op_q.x);
   assign in_bounds = (px < X_LIM) && (py < Y_LIM);

   gpu_tex_stepper #(
      .ROM_ADDR_W(ROM_ADDR_W)
   ) u_stepper (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (setup),
      .step     (step),
      .width    (op_q.width),
      .height   (op_q.height),
      .scale    (op_q.scale),
      .base     (ROM_ADDR_W'(op_q.mem_addr)),
      .col_end  (col_end),
      .last     (last),
      .tex_addr (rom_addr)
   );

   always_comb begin
      next_state = state;
      accept     = 1'b0;
      setup      = 1'b0;
      step       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (op_valid && op_ready) begin
               accept     = 1'b1;
               next_state = ST_SETUP;
            end
         end
         ST_SETUP: begin
            setup      = 1'b1;
            next_state = zero_size ? ST_IDLE : ST_DRAW;
         end
         ST_DRAW: begin
            step = 1'b1;
            if (last)
               next_state = ST_DRAIN;
         end
         ST_DRAIN: next_state = ST_IDLE;
         default:  next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= next_state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q     <= '0;
         op_ready <= 1'b0;
         row_addr <= '0;
         pix_addr <= '0;
         px       <= '0;
         py       <= '0;
         s1_valid <= 1'b0;
         s1_addr  <= '0;
      end else begin
         if (accept)
            op_q <= op;
         op_ready <= (next_state == ST_IDLE);
         // clipped pixels still take their cycle, they just never strobe
         s1_valid <= step && in_bounds;
         if (step)
            s1_addr <= pix_addr;
         if (setup) begin
            row_addr <= base_addr;
            pix_addr <= base_addr;
            px       <= {1'b0, op_q.x};
            py       <= {1'b0, op_q.y};
         end else if (step) begin
            if (col_end) begin
               row_addr <= row_addr + PITCH;
               pix_addr <= row_addr + PITCH;
               px       <= {1'b0, op_q.x};
               py       <= py + 1'b1;
            end else begin
               pix_addr <= pix_addr + 1'b1;
               px       <= px + 1'b1;
            end
         end
      end
   end

   assign fb_wr_en   = s1_valid && !(KEY_EN && op_q.mem_en && (rom_data == TRANSPARENT_COLOR));
   assign fb_wr_addr = s1_addr;
   assign fb_wr_data = s1_valid ? (op_q.mem_en ? rom_data : op_q.color) : '0;

endmodule

// File: tb/tb_gpu_rect_blitter.sv
// tb/tb_gpu_rect_blitter.sv - directed bench for gpu_rect_blitter on an 8x4 framebuffer
module tb_gpu_rect_blitter;
   import gpu_pkg::*;

   localparam int HOR = 8;
   localparam int VER = 4;
   localparam int AW  = $clog2(HOR * VER);
   localparam int RAW = 12;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   gpu_op_t            op;
   logic               op_valid;
   logic               op_ready;
   logic [RAW-1:0]     rom_addr;
   logic [COLOR_W-1:0] rom_data;
   logic               fb_wr_en;
   logic [AW-1:0]      fb_wr_addr;
   logic [COLOR_W-1:0] fb_wr_data;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   logic [COLOR_W-1:0] rom [0:(1<<RAW)-1];
   int wa[$];
   int wd[$];
   int wc[$];
   int rom_log [0:4095];

   gpu_rect_blitter #(
      .HOR_ACTIVE_PIXELS (HOR),
      .VER_ACTIVE_PIXELS (VER),
      .ROM_ADDR_W        (RAW),
      .TRANSPARENT_COLOR (12'hF0F)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op         (op),
      .op_valid   (op_valid),
      .op_ready   (op_ready),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .fb_wr_en   (fb_wr_en),
      .fb_wr_addr (fb_wr_addr),
      .fb_wr_data (fb_wr_data)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rom_data <= rom[rom_addr];
   end

   always @(negedge clk) begin
      if (fb_wr_en === 1'b1) begin
         wa.push_back(int'(fb_wr_addr));
         wd.push_back(int'(fb_wr_data));
         wc.push_back(cyc);
      end
      if (cyc < 4096)
         rom_log[cyc] = int'(rom_addr);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic gpu_op_t mk(input int x, input int y, input int w, input int h,
                                  input int color, input int mem_en, input int maddr, input int scale);
      gpu_op_t o;
      o.x        = X_W'(x);
      o.y        = Y_W'(y);
      o.width    = X_W'(w);
      o.height   = Y_W'(h);
      o.color    = COLOR_W'(color);
      o.mem_en   = mem_en[0];
      o.mem_addr = MEM_ADDR_W'(maddr);
      o.scale    = SCALE_W'(scale);
      return o;
   endfunction

   task automatic clear_log();
      wa.delete();
      wd.delete();
      wc.delete();
   endtask

   task automatic send_op(input gpu_op_t o, output int t);
      clear_log();
      @(negedge clk);
      op       = o;
      op_valid = 1'b1;
      @(negedge clk);
      t        = cyc;
      op_valid = 1'b0;
      op       = '0;
      check("accept_clears_ready", op_ready, 0);
   endtask

   task automatic wait_ready(input int t, output int d);
      d = -1;
      for (int i = 0; i < 300; i++) begin
         if (op_ready === 1'b1) begin
            d = cyc - t;
            break;
         end
         @(negedge clk);
      end
   endtask

   initial begin
      int t;
      int d;
      int fill_addr [8];
      logic [COLOR_W-1:0] pat [4];
      fill_addr = '{9, 10, 11, 12, 17, 18, 19, 20};
      pat       = '{12'hAAA, 12'hBBB, 12'hCCC, 12'hDDD};
      for (int i = 0; i < (1<<RAW); i++)
         rom[i] = COLOR_W'(i + 'h100);
      for (int i = 0; i < 4; i++)
         rom[16+i] = pat[i];
      op       = '0;
      op_valid = 1'b0;

      // reset values
      repeat (2) @(negedge clk);
      check("rst_op_ready", op_ready, 0);
      check("rst_fb_wr_en", fb_wr_en, 0);
      check("rst_fb_wr_addr", fb_wr_addr, 0);
      check("rst_fb_wr_data", fb_wr_data, 0);
      check("rst_rom_addr", rom_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", op_ready, 1);

      // solid fill
      send_op(mk(1, 1, 4, 2, 'hF00, 0, 0, 0), t);
      wait_ready(t, d);
      check("fill_ready_delay", d, 10);
      check("fill_count", wa.size(), 8);
      for (int k = 0; k < 8; k++) begin
         check("fill_addr", wa[k], fill_addr[k]);
         check("fill_data", wd[k], 'hF00);
      end
      check("fill_first_cyc", wc[0] - t, 2);
      check("fill_last_cyc", wc[7] - t, 9);

      // 2x magnified sprite
      send_op(mk(0, 0, 4, 4, 'h000, 1, 16, 1), t);
      wait_ready(t, d);
      check("sprite_ready_delay", d, 18);
      check("sprite_count", wa.size(), 16);
      for (int k = 0; k < 16; k++) begin
         int r;
         int c;
         int idx;
         r   = k / 4;
         c   = k % 4;
         idx = (r / 2) * 2 + c / 2;
         check("sprite_rom_addr", rom_log[t+1+k], 16 + idx);
         check("sprite_addr", wa[k], r * HOR + c);
         check("sprite_data", wd[k], pat[idx]);
      end

      // clipped at right and bottom edges
      send_op(mk(6, 3, 4, 2, 'h0F0, 0, 0, 0), t);
      wait_ready(t, d);
      check("clip_ready_delay", d, 10);
      check("clip_count", wa.size(), 2);
      check("clip_addr0", wa[0], 30);
      check("clip_addr1", wa[1], 31);
      check("clip_data0", wd[0], 'h0F0);
      check("clip_cyc0", wc[0] - t, 2);
      check("clip_cyc1", wc[1] - t, 3);

      // zero width
      send_op(mk(0, 0, 0, 5, 'h555, 0, 0, 0), t);
      wait_ready(t, d);
      check("zero_ready_delay", d, 1);
      check("zero_count", wa.size(), 0);

      // op_valid while busy is ignored
      send_op(mk(0, 0, 2, 1, 'h123, 0, 0, 0), t);
      op       = mk(5, 0, 1, 1, 'h999, 0, 0, 0);
      op_valid = 1'b1;
      @(negedge clk);
      op_valid = 1'b0;
      op       = '0;
      check("busy_ready_low", op_ready, 0);
      wait_ready(t, d);
      check("busy_ready_delay", d, 4);
      check("busy_count", wa.size(), 2);
      check("busy_addr0", wa[0], 0);
      check("busy_addr1", wa[1], 1);
      check("busy_data1", wd[1], 'h123);

      // back-to-back accept on the first cycle ready is seen
      clear_log();
      op       = mk(2, 2, 1, 1, 'h456, 0, 0, 0);
      op_valid = 1'b1;
      @(negedge clk);
      t        = cyc;
      op_valid = 1'b0;
      op       = '0;
      check("b2b_accepted", op_ready, 0);
      wait_ready(t, d);
      check("b2b_ready_delay", d, 3);
      check("b2b_count", wa.size(), 1);
      check("b2b_addr", wa[0], 18);
      check("b2b_data", wd[0], 'h456);

      // reset during pixel 3 of a 4x4 fill
      send_op(mk(0, 0, 4, 4, 'h777, 0, 0, 0), t);
      repeat (5) @(negedge clk);
      check("mid_pixel3_en", fb_wr_en, 1);
      check("mid_pixel3_addr", fb_wr_addr, 3);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_wr_en", fb_wr_en, 0);
      check("mid_rst_wr_data", fb_wr_data, 0);
      check("mid_rst_ready", op_ready, 0);
      clear_log();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("mid_ready_after", op_ready, 1);
      repeat (20) @(negedge clk);
      check("mid_no_residual", wa.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
